// File: rtl/gba_sound_pkg.sv
// Shared definitions for the DMA-sound sample path.
// Contents:
//   FIFO_DEPTH   - number of 32-bit entries per channel FIFO
//   FIFO_ADDR_W  - pointer width (log2 of FIFO_DEPTH)
//   fifo_size_t  - type of the fill-level output
//   fifo_mask_t  - decoded half-word select of a FIFO register write
package gba_sound_pkg;

    localparam int FIFO_DEPTH  = 8;
    localparam int FIFO_ADDR_W = 3;

    typedef logic [3:0] fifo_size_t;

    // Encoding matches the raw wr_mask bits so a plain cast decodes it.
    typedef enum logic [1:0] {
        MASK_NONE = 2'b00,
        MASK_LO   = 2'b01,
        MASK_HI   = 2'b10,
        MASK_WORD = 2'b11
    } fifo_mask_t;

endpackage : gba_sound_pkg

// File: rtl/direct_sound_fifo.sv
// Sample FIFO for one DMA-sound channel, feeding direct_sound.
// Ports:
//   clock       in   system clock
//   reset       in   asynchronous active-high reset
//   wr_en       in   register-write strobe, one cycle per access
//   wr_mask     in   half select: 11 word, 01 low half, 10 high half, 00 no-op
//   wr_data     in   write data, low half [15:0], high half [31:16]
//   FIFO_re     in   pop head entry
//   FIFO_clr    in   flush FIFO (highest priority)
//   FIFO_size   out  entries held, 0..DEPTH (registered)
//   FIFO_value  out  head entry, 32'h0 when empty
//   overflow    out  one-cycle pulse: push dropped because FIFO full
//   underflow   out  one-cycle pulse: pop requested while empty
module direct_sound_fifo
    import gba_sound_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  wr_mask,
    input  logic [31:0] wr_data,
    input  logic        FIFO_re,
    input  logic        FIFO_clr,
    output logic [3:0]  FIFO_size,
    output logic [31:0] FIFO_value,
    output logic        overflow,
    output logic        underflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [31:0]     mem_r [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W:0] count_r;
    logic [15:0]     lo_latch_r;
    logic            overflow_r;
    logic            underflow_r;

    fifo_mask_t      mask_s;
    logic            push_req_s;
    logic [31:0]     push_data_s;
    logic [15:0]     lo_latch_next_s;
    logic            empty_s;
    logic            full_s;
    logic            pop_ok_s;
    logic            push_ok_s;
    logic [ADDR_W:0] count_next_s;
    logic            overflow_next_s;
    logic            underflow_next_s;

    // Decode the register write into a push request and the next low-half latch value.
    always_comb begin
        mask_s          = fifo_mask_t'(wr_mask);
        push_req_s      = 1'b0;
        push_data_s     = 32'h0;
        lo_latch_next_s = lo_latch_r;
        if (wr_en) begin
            case (mask_s)
                MASK_WORD: begin
                    push_req_s  = 1'b1;
                    push_data_s = wr_data;
                end
                MASK_LO: begin
                    lo_latch_next_s = wr_data[15:0];
                end
                MASK_HI: begin
                    // High-half write completes the pair; the latch is consumed even if the push is dropped.
                    push_req_s      = 1'b1;
                    push_data_s     = {wr_data[31:16], lo_latch_r};
                    lo_latch_next_s = 16'h0;
                end
                MASK_NONE: begin
                    lo_latch_next_s = lo_latch_r;
                end
                default: begin
                    lo_latch_next_s = lo_latch_r;
                end
            endcase
        end else begin
            lo_latch_next_s = lo_latch_r;
        end
    end

    // Arbitrate push/pop against fill level; a pop frees the slot for a same-cycle push when full.
    always_comb begin
        empty_s          = (count_r == {(ADDR_W + 1){1'b0}});
        full_s           = (count_r == FULL_COUNT);
        pop_ok_s         = FIFO_re && !empty_s && !FIFO_clr;
        push_ok_s        = push_req_s && (!full_s || pop_ok_s) && !FIFO_clr;
        overflow_next_s  = push_req_s && full_s && !pop_ok_s && !FIFO_clr;
        underflow_next_s = FIFO_re && empty_s && !FIFO_clr;
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + {{ADDR_W{1'b0}}, 1'b1};
        end else if (pop_ok_s && !push_ok_s) begin
            count_next_s = count_r - {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            count_next_s = count_r;
        end
    end

    // Storage, pointers, count, latch and status pulses; clear outranks every other update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0;
            end
            rd_ptr_r    <= {ADDR_W{1'b0}};
            wr_ptr_r    <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W + 1){1'b0}};
            lo_latch_r  <= 16'h0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (FIFO_clr) begin
            rd_ptr_r    <= {ADDR_W{1'b0}};
            wr_ptr_r    <= {ADDR_W{1'b0}};
            count_r     <= {(ADDR_W + 1){1'b0}};
            lo_latch_r  <= 16'h0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
            end
            count_r     <= count_next_s;
            lo_latch_r  <= lo_latch_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
        end
    end

    // Head entry is forced to zero when nothing is held so stale storage never leaks out.
    always_comb begin
        if (count_r != {(ADDR_W + 1){1'b0}}) begin
            FIFO_value = mem_r[rd_ptr_r];
        end else begin
            FIFO_value = 32'h0;
        end
    end

    assign FIFO_size = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule : direct_sound_fifo

// File: tb/tb_direct_sound_fifo.sv
// Directed self-checking bench for direct_sound_fifo.
module tb_direct_sound_fifo;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_mask;
    logic [31:0] wr_data;
    logic        FIFO_re;
    logic        FIFO_clr;
    logic [3:0]  FIFO_size;
    logic [31:0] FIFO_value;
    logic        overflow;
    logic        underflow;

    int vectors;
    int errors;

    direct_sound_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .FIFO_re    (FIFO_re),
        .FIFO_clr   (FIFO_clr),
        .FIFO_size  (FIFO_size),
        .FIFO_value (FIFO_value),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        wr_mask  = 2'b00;
        wr_data  = 32'h0;
        FIFO_re  = 1'b0;
        FIFO_clr = 1'b0;
    endtask

    task automatic push(input logic [1:0] m, input logic [31:0] d);
        wr_en = 1'b1; wr_mask = m; wr_data = d;
        tick();
        idle();
    endtask

    task automatic pop();
        FIFO_re = 1'b1;
        tick();
        idle();
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_size", {28'h0, FIFO_size}, 32'd0);
        check("rst_value", FIFO_value, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'd0);
        check("rst_unf", {31'h0, underflow}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: two word pushes then a pop
        push(2'b11, 32'h11223344);
        push(2'b11, 32'h55667788);
        check("t1_size2", {28'h0, FIFO_size}, 32'd2);
        check("t1_head", FIFO_value, 32'h11223344);
        pop();
        check("t1_head_after_pop", FIFO_value, 32'h55667788);
        check("t1_size1", {28'h0, FIFO_size}, 32'd1);
        pop();
        check("t1_empty_value", FIFO_value, 32'h0);

        // 2: half-word pair assembly
        push(2'b01, 32'hFFFFBBAA);
        check("t2_lo_no_push", {28'h0, FIFO_size}, 32'd0);
        push(2'b10, 32'hDDCC9999);
        check("t2_size", {28'h0, FIFO_size}, 32'd1);
        check("t2_pair", FIFO_value, 32'hDDCCBBAA);
        pop();

        // 3: overflow on 9th push, ordered drain
        for (int i = 0; i < 8; i++) push(2'b11, i);
        check("t3_size_full", {28'h0, FIFO_size}, 32'd8);
        check("t3_no_ovf_yet", {31'h0, overflow}, 32'd0);
        push(2'b11, 32'd8);
        check("t3_ovf_pulse", {31'h0, overflow}, 32'd1);
        check("t3_size_still8", {28'h0, FIFO_size}, 32'd8);
        tick();
        check("t3_ovf_one_cycle", {31'h0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("t3_drain_order", FIFO_value, i);
            pop();
        end
        check("t3_drained_size", {28'h0, FIFO_size}, 32'd0);
        check("t3_drained_value", FIFO_value, 32'h0);
        check("t3_no_unf", {31'h0, underflow}, 32'd0);

        // 4: full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(2'b11, 32'h100 + i);
        wr_en = 1'b1; wr_mask = 2'b11; wr_data = 32'hCAFE0000; FIFO_re = 1'b1;
        tick();
        idle();
        check("t4_size8", {28'h0, FIFO_size}, 32'd8);
        check("t4_no_ovf", {31'h0, overflow}, 32'd0);
        check("t4_head", FIFO_value, 32'h101);
        for (int i = 1; i < 8; i++) pop();
        check("t4_tail", FIFO_value, 32'hCAFE0000);
        pop();
        check("t4_empty", {28'h0, FIFO_size}, 32'd0);

        // 5: underflow, then push+pop on empty
        pop();
        check("t5_unf_pulse", {31'h0, underflow}, 32'd1);
        check("t5_size0", {28'h0, FIFO_size}, 32'd0);
        tick();
        check("t5_unf_one_cycle", {31'h0, underflow}, 32'd0);
        wr_en = 1'b1; wr_mask = 2'b11; wr_data = 32'h1; FIFO_re = 1'b1;
        tick();
        idle();
        check("t5_pushpop_size", {28'h0, FIFO_size}, 32'd1);
        check("t5_pushpop_value", FIFO_value, 32'h1);
        check("t5_pushpop_unf", {31'h0, underflow}, 32'd1);
        pop();
        check("t5_final_empty", {28'h0, FIFO_size}, 32'd0);

        // 6: clear with simultaneous push, then lo-latch clear paths
        for (int i = 0; i < 5; i++) push(2'b11, 32'hA0 + i);
        check("t6_size5", {28'h0, FIFO_size}, 32'd5);
        wr_en = 1'b1; wr_mask = 2'b11; wr_data = 32'hDEAD; FIFO_clr = 1'b1;
        tick();
        idle();
        check("t6_clr_size", {28'h0, FIFO_size}, 32'd0);
        check("t6_clr_value", FIFO_value, 32'h0);
        check("t6_clr_ovf", {31'h0, overflow}, 32'd0);
        check("t6_clr_unf", {31'h0, underflow}, 32'd0);
        push(2'b01, 32'h00005555);
        FIFO_clr = 1'b1;
        tick();
        idle();
        push(2'b10, 32'h77770000);
        check("t6_clr_latch", FIFO_value, 32'h77770000);
        pop();

        // reset mid-stream clears outputs immediately and drops the latched low half
        push(2'b11, 32'h5A5A5A5A);
        push(2'b01, 32'h00001234);
        check("t6_pre_rst_size", {28'h0, FIFO_size}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_rst_size", {28'h0, FIFO_size}, 32'd0);
        check("t6_async_rst_value", FIFO_value, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        push(2'b10, 32'hABCD0000);
        check("t6_rst_latch", FIFO_value, 32'hABCD0000);
        check("t6_rst_size", {28'h0, FIFO_size}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_direct_sound_fifo
